inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_inta_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// inta_sequencer: bus sequencer between a host, a CPU vector handshake and an
// 8259-style PIC. It runs either a two-pulse INTA cycle that fetches the
// interrupt vector, or a single register read/write access. An interrupt takes
// priority over a pending host request. All bus outputs come straight from
// flops.
module inta_sequencer #(
  parameter int unsigned PULSE_W  = 2,  // clk cycles per INTA low pulse (1..15)
  parameter int unsigned GAP_W    = 2,  // clk cycles inta_n is high between pulses (1..15)
  parameter int unsigned STROBE_W = 2   // clk cycles wr_n/rd_n is low per access (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  // PIC side
  input  logic       int_in,
  output logic       inta_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  // Host register-access side
  input  logic       req,
  input  logic       req_rw,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic       req_ack,
  output logic [7:0] rd_data,
  // CPU vector side
  output logic [7:0] vec,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAck1    = 3'd1,
    StGap     = 3'd2,
    StAck2    = 3'd3,
    StVecOut  = 3'd4,
    StXSetup  = 3'd5,
    StXStrobe = 3'd6,
    StXHold   = 3'd7
  } state_e;

  // The down-counter is loaded with (width - 1) on entry and the phase ends
  // on the cycle it reads zero, so each phase lasts exactly "width" cycles.
  localparam logic [3:0] PulseLoad  = 4'(PULSE_W - 1);
  localparam logic [3:0] GapLoad    = 4'(GAP_W - 1);
  localparam logic [3:0] StrobeLoad = 4'(STROBE_W - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic       int_s;

  // Latched access fields and captured data
  logic       rw_q, rw_d;
  logic       a0_q, a0_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] vec_q, vec_d;

  // Registered strobes and status, decoded from the next state
  logic inta_n_q, inta_n_d;
  logic cs_n_q, cs_n_d;
  logic wr_n_q, wr_n_d;
  logic rd_n_q, rd_n_d;
  logic d_oe_q, d_oe_d;
  logic req_ack_q, req_ack_d;
  logic vec_valid_q, vec_valid_d;
  logic busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous PIC INT line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], int_in};
    end
  end

  assign int_s = sync_q[1];

  // Next-state, counter and data-capture logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    a0_d      = a0_q;
    dout_d    = dout_q;
    rd_data_d = rd_data_q;
    vec_d     = vec_q;

    unique case (state_q)
      StIdle: begin
        if (int_s) begin
          state_d = StAck1;
          cnt_d   = PulseLoad;
        end else if (req) begin
          // Fields are latched on entry so they are stable for the whole access
          state_d = StXSetup;
          rw_d    = req_rw;
          a0_d    = req_a0;
          dout_d  = req_data;
        end
      end

      StAck1: begin
        if (cnt_q == 4'd0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StGap: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck2;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StAck2: begin
        if (cnt_q == 4'd0) begin
          // The PIC drives the vector during the second pulse
          state_d = StVecOut;
          vec_d   = d_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StVecOut: begin
        if (vec_ready) begin
          state_d = StIdle;
        end
      end

      StXSetup: begin
        state_d = StXStrobe;
        cnt_d   = StrobeLoad;
      end

      StXStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StXHold;
          if (!rw_q) begin
            rd_data_d = d_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StXHold: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so every bus pin is a flop output
  always_comb begin
    inta_n_d    = 1'b1;
    cs_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    d_oe_d      = 1'b0;
    req_ack_d   = 1'b0;
    vec_valid_d = 1'b0;
    busy_d      = (state_d != StIdle);

    unique case (state_d)
      StAck1, StAck2: begin
        inta_n_d = 1'b0;
      end
      StVecOut: begin
        vec_valid_d = 1'b1;
      end
      StXSetup: begin
        cs_n_d = 1'b0;
        d_oe_d = rw_d;
      end
      StXStrobe: begin
        cs_n_d = 1'b0;
        d_oe_d = rw_d;
        wr_n_d = ~rw_d;
        rd_n_d = rw_d;
      end
      StXHold: begin
        cs_n_d    = 1'b0;
        d_oe_d    = rw_d;
        req_ack_d = 1'b1;
      end
      default: begin
        inta_n_d = 1'b1;
      end
    endcase
  end

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      a0_q      <= 1'b0;
      dout_q    <= 8'h00;
      rd_data_q <= 8'h00;
      vec_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      a0_q      <= a0_d;
      dout_q    <= dout_d;
      rd_data_q <= rd_data_d;
      vec_q     <= vec_d;
    end
  end

  // Registered strobes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_n_q    <= 1'b1;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      d_oe_q      <= 1'b0;
      req_ack_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      inta_n_q    <= inta_n_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      d_oe_q      <= d_oe_d;
      req_ack_q   <= req_ack_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign rd_n      = rd_n_q;
  assign a0        = a0_q;
  assign d_out     = dout_q;
  assign d_oe      = d_oe_q;
  assign req_ack   = req_ack_q;
  assign rd_data   = rd_data_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;

  // Bus-protocol invariants
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n) (wr_n_q | rd_n_q));
  a_inta_no_cs  : assert property (@(posedge clk) disable iff (!rst_n)
                                   (!inta_n_q |-> (cs_n_q && !d_oe_q)));
  a_rd_no_drive : assert property (@(posedge clk) disable iff (!rst_n) (!rd_n_q |-> !d_oe_q));
  a_vec_hold    : assert property (@(posedge clk) disable iff (!rst_n)
                                   (vec_valid_q && !vec_ready |=> vec_valid_q && $stable(vec_q)));

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed and random host accesses and interrupts
// against a small PIC model; a monitor scores completions from a queue of
// expected results and checks pulse/strobe/chip-select timing.
module tb_inta_sequencer;

  localparam int PulseW  = 2;
  localparam int GapW    = 2;
  localparam int StrobeW = 2;

  localparam int KWrite = 0;
  localparam int KRead  = 1;
  localparam int KVec   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       a0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_in;
  logic       inta_n, cs_n, wr_n, rd_n, a0, d_oe;
  logic [7:0] d_out, d_in;
  logic       req, req_rw, req_a0;
  logic [7:0] req_data;
  logic       req_ack;
  logic [7:0] rd_data, vec;
  logic       vec_valid, vec_ready, busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // PIC model state
  logic [7:0] pic_reg [2];
  logic [7:0] pic_vec;
  logic       pic_first;

  always #5 clk = ~clk;

  inta_sequencer #(
    .PULSE_W (PulseW),
    .GAP_W   (GapW),
    .STROBE_W(StrobeW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_in   (int_in),
    .inta_n   (inta_n),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .a0       (a0),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .d_in     (d_in),
    .req      (req),
    .req_rw   (req_rw),
    .req_a0   (req_a0),
    .req_data (req_data),
    .req_ack  (req_ack),
    .rd_data  (rd_data),
    .vec      (vec),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .busy     (busy)
  );

  // PIC: first INTA pulse drives nothing, second drives the vector
  always @(negedge inta_n or negedge rst_n) begin
    if (!rst_n) pic_first <= 1'b0;
    else        pic_first <= ~pic_first;
  end

  always_comb begin
    d_in = 8'h00;
    if (!inta_n && !pic_first) d_in = pic_vec;
    else if (!rd_n && !cs_n)   d_in = pic_reg[a0];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_inta_n", inta_n, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_a0", a0, 0);
    check("rst_d_oe", d_oe, 0);
    check("rst_d_out", d_out, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_vec", vec, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  // Monitor: timing runs and scoreboard pops
  int         inta_run, gap_run, pulses, wr_run, rd_run, cs_run, oe_ones;
  bit         saw_wr, last_write, prev_vv;
  logic [7:0] strobe_data, held_vec;
  logic       strobe_a0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      inta_run = 0; gap_run = 0; pulses = 0; wr_run = 0; rd_run = 0;
      cs_run = 0; oe_ones = 0; saw_wr = 0; prev_vv = 0;
    end else begin
      if (!inta_n) begin
        if (gap_run > 0) begin
          check("inta_gap_len", gap_run, GapW);
          gap_run = 0;
        end
        inta_run++;
        check("inta_bus_quiet", {cs_n, d_oe}, 2'b10);
      end else begin
        if (inta_run > 0) begin
          check("inta_pulse_len", inta_run, PulseW);
          inta_run = 0;
          pulses++;
        end
        if (pulses % 2 == 1) gap_run++;
      end

      if (!wr_n) begin
        wr_run++; strobe_data = d_out; strobe_a0 = a0;
      end else if (wr_run > 0) begin
        check("wr_strobe_len", wr_run, StrobeW);
        wr_run = 0; last_write = 1;
      end
      if (!rd_n) begin
        rd_run++; strobe_a0 = a0;
      end else if (rd_run > 0) begin
        check("rd_strobe_len", rd_run, StrobeW);
        rd_run = 0; last_write = 0;
      end

      if (!cs_n) begin
        cs_run++;
        if (d_oe) oe_ones++;
        if (!wr_n) saw_wr = 1;
      end else if (cs_run > 0) begin
        check("cs_low_len", cs_run, StrobeW + 2);
        check("d_oe_cycles", oe_ones, saw_wr ? cs_run : 0);
        cs_run = 0; oe_ones = 0; saw_wr = 0;
      end

      if (!cs_n || !inta_n || vec_valid) check("busy_active", busy, 1);

      if (req_ack) begin
        check("ack_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ack_kind", last_write ? KWrite : KRead, e.kind);
          check("access_a0", strobe_a0, e.a0);
          if (last_write) check("write_data", strobe_data, e.data);
          else            check("read_data", rd_data, e.data);
        end
      end

      if (vec_valid && !prev_vv) begin
        check("vec_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("vec_kind", KVec, e.kind);
          check("vec_value", vec, e.data);
        end
        held_vec = vec;
      end else if (vec_valid) begin
        check("vec_stable", vec, held_vec);
      end
      // vec_ready seen here is the value the DUT sampled at the last edge
      if (prev_vv) check("vec_valid_hold", vec_valid, int'(!vec_ready));
      prev_vv = vec_valid;
    end
  end

  task automatic do_access(input bit rw, input bit a, input logic [7:0] data);
    exp_t e;
    int   n;
    if (!rw) pic_reg[a] = data;
    e.kind = rw ? KWrite : KRead; e.data = data; e.a0 = a;
    exp_q.push_back(e);
    req = 1; req_rw = rw; req_a0 = a; req_data = data;
    tick();
    // Fields are latched by now; disturbing them must not matter
    req_rw = ~rw; req_a0 = ~a; req_data = ~data;
    n = 1;
    while (!req_ack && n < 40) begin tick(); n++; end
    check("ack_arrives", req_ack, 1);
    req = 0;
    tick();
  endtask

  task automatic vec_handshake();
    int n = 0;
    while (!vec_valid && n < 40) begin tick(); n++; end
    check("vec_valid_arrives", vec_valid, 1);
    repeat ($urandom_range(0, 3)) tick();
    vec_ready = 1;
    tick();
    vec_ready = 0;
    tick();
  endtask

  task automatic do_int(input logic [7:0] v, input bit late_drop);
    exp_t e;
    int   lat = 0;
    int   n   = 0;
    pic_vec = v;
    e.kind = KVec; e.data = v; e.a0 = 0;
    exp_q.push_back(e);
    int_in = 1;
    do begin tick(); lat++; end while (inta_n && lat < 10);
    check("int_latency", lat, 3);
    if (late_drop) begin
      while (!inta_n && n < 20) begin tick(); n++; end
    end
    int_in = 0;
    vec_handshake();
    tick();
  endtask

  task automatic do_simul(input logic [7:0] v, input bit a, input logic [7:0] data);
    exp_t e;
    int   n = 0;
    pic_vec = v;
    e.kind = KVec; e.data = v; e.a0 = 0;
    exp_q.push_back(e);
    e.kind = KWrite; e.data = data; e.a0 = a;
    exp_q.push_back(e);
    int_in = 1;
    tick();
    tick();
    req = 1; req_rw = 1; req_a0 = a; req_data = data;
    while (inta_n && n < 10) begin tick(); n++; end
    int_in = 0;
    vec_handshake();
    n = 0;
    while (!req_ack && n < 40) begin tick(); n++; end
    check("simul_ack_arrives", req_ack, 1);
    req = 0;
    tick();
  endtask

  task automatic do_reset_abort();
    exp_t e;
    int   n = 0;
    e.kind = KWrite; e.data = 8'h5A; e.a0 = 0;
    exp_q.push_back(e);
    req = 1; req_rw = 1; req_a0 = 0; req_data = 8'h5A;
    while (wr_n && n < 20) begin tick(); n++; end
    tick();
    check("wr_second_cycle", wr_n, 0);
    exp_q.delete();
    rst_n = 0;
    req   = 0;
    #1;
    check_reset_outputs();
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1;
    repeat (3) tick();
    check("no_ack_after_abort", req_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; int_in = 0; req = 0; req_rw = 0; req_a0 = 0; req_data = 0;
    vec_ready = 0; pic_vec = 0; pic_reg[0] = 0; pic_reg[1] = 0;
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1;
    tick();

    do_access(1'b1, 1'b0, 8'h13);
    do_int(8'h48, 1'b0);
    do_access(1'b0, 1'b1, 8'hA5);
    do_simul(8'h21, 1'b1, 8'h7E);
    do_int(8'h93, 1'b1);
    do_reset_abort();
    do_access(1'b1, 1'b1, 8'hC3);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: do_access(1'b1, 1'($urandom), 8'($urandom));
        1: do_access(1'b0, 1'($urandom), 8'($urandom));
        2: do_int(8'($urandom), 1'($urandom));
        default: do_simul(8'($urandom), 1'($urandom), 8'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
